// File: rtl/wb_stream_reader_seq.sv
// Wishbone write-only master that programs the stream-reader cfg block once per ring buffer,
// waits for its done irq (or a watchdog), acknowledges it and advances around the ring.
module wb_stream_reader_seq #(
  parameter int unsigned WB_AW = 32,
  parameter int unsigned WB_DW = 32,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned TMO_W = 24
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  input  logic               go_i,
  input  logic               stop_i,
  input  logic [WB_AW-1:0]   ring_base_i,
  input  logic [WB_AW-1:0]   buf_stride_i,
  input  logic [IDX_W-1:0]   num_bufs_i,
  input  logic [WB_AW-1:0]   buf_size_i,
  input  logic [WB_AW-1:0]   burst_size_i,
  input  logic [TMO_W-1:0]   timeout_i,
  input  logic               rdr_irq_i,
  output logic [4:0]         wbm_adr_o,
  output logic [WB_DW-1:0]   wbm_dat_o,
  output logic [WB_DW/8-1:0] wbm_sel_o,
  output logic               wbm_we_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  input  logic               wbm_ack_i,
  output logic               running_o,
  output logic [IDX_W-1:0]   cur_idx_o,
  output logic               frame_done_o,
  output logic [31:0]        frame_cnt_o,
  output logic               timeout_err_o
);

  typedef enum logic [2:0] {
    StIdle, StWrBsz, StWrBurst, StWrAdr, StWrEn, StWait, StWrClr, StWrRst
  } state_e;

  state_e             state_q;
  logic               cyc_q;
  logic [4:0]         adr_q;
  logic [WB_DW-1:0]   dat_q;
  logic [WB_AW-1:0]   base_q, stride_q, bsz_q, burst_q, addr_q;
  logic [IDX_W-1:0]   last_q, idx_q;
  logic [TMO_W-1:0]   wdog_q;
  logic               wdog_en_q, stop_q, done_q, terr_q;
  logic [31:0]        cnt_q;

  logic [4:0]         wr_adr;
  logic [WB_DW-1:0]   wr_dat;
  state_e             wr_next;

  // Register address, data and successor for the write owned by the current state.
  always_comb begin
    wr_adr  = 5'h00;
    wr_dat  = '0;
    wr_next = StIdle;
    unique case (state_q)
      StWrBsz:   begin wr_adr = 5'h08; wr_dat = WB_DW'(bsz_q);   wr_next = StWrBurst; end
      StWrBurst: begin wr_adr = 5'h0C; wr_dat = WB_DW'(burst_q); wr_next = StWrAdr;   end
      StWrAdr:   begin wr_adr = 5'h04; wr_dat = WB_DW'(addr_q);  wr_next = StWrEn;    end
      StWrEn:    begin wr_adr = 5'h00; wr_dat = WB_DW'(3);       wr_next = StWait;    end
      StWrClr: begin
        wr_adr  = 5'h00;
        wr_dat  = WB_DW'(2);
        wr_next = (stop_q || stop_i) ? StIdle : StWrAdr;
      end
      StWrRst:   begin wr_adr = 5'h00; wr_dat = WB_DW'(4);       wr_next = StIdle;    end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= StIdle;
      cyc_q     <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      base_q    <= '0;
      stride_q  <= '0;
      bsz_q     <= '0;
      burst_q   <= '0;
      addr_q    <= '0;
      last_q    <= '0;
      idx_q     <= '0;
      wdog_q    <= '0;
      wdog_en_q <= 1'b0;
      stop_q    <= 1'b0;
      done_q    <= 1'b0;
      terr_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q != StIdle && stop_i) stop_q <= 1'b1;
      case (state_q)
        StIdle: begin
          if (go_i && !stop_i) begin
            base_q   <= ring_base_i;
            stride_q <= buf_stride_i;
            bsz_q    <= buf_size_i;
            burst_q  <= burst_size_i;
            last_q   <= (num_bufs_i == '0) ? '0 : num_bufs_i - IDX_W'(1);
            addr_q   <= ring_base_i;
            idx_q    <= '0;
            cnt_q    <= '0;
            terr_q   <= 1'b0;
            state_q  <= StWrBsz;
          end
        end
        StWait: begin
          // A simultaneous irq beats watchdog expiry.
          if (rdr_irq_i) begin
            state_q <= StWrClr;
          end else if (wdog_en_q) begin
            if (wdog_q == TMO_W'(1)) state_q <= StWrRst;
            else                     wdog_q  <= wdog_q - TMO_W'(1);
          end
        end
        default: begin
          // Entering a write state leaves cyc low for one cycle: the mandatory idle gap.
          if (!cyc_q) begin
            cyc_q <= 1'b1;
            adr_q <= wr_adr;
            dat_q <= wr_dat;
          end else if (wbm_ack_i) begin
            cyc_q   <= 1'b0;
            state_q <= wr_next;
            if (state_q == StWrEn) begin
              wdog_q    <= timeout_i;
              wdog_en_q <= (timeout_i != '0);
            end
            if (state_q == StWrClr) begin
              done_q <= 1'b1;
              cnt_q  <= cnt_q + 32'd1;
              if (idx_q == last_q) begin
                idx_q  <= '0;
                addr_q <= base_q;
              end else begin
                idx_q  <= idx_q + IDX_W'(1);
                addr_q <= addr_q + stride_q;
              end
              if (stop_q || stop_i) stop_q <= 1'b0;
            end
            if (state_q == StWrRst) begin
              terr_q <= 1'b1;
              stop_q <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign wbm_adr_o     = adr_q;
  assign wbm_dat_o     = dat_q;
  assign wbm_sel_o     = {(WB_DW/8){cyc_q}};
  assign wbm_we_o      = cyc_q;
  assign wbm_cyc_o     = cyc_q;
  assign wbm_stb_o     = cyc_q;
  assign running_o     = (state_q != StIdle);
  assign cur_idx_o     = idx_q;
  assign frame_done_o  = done_q;
  assign frame_cnt_o   = cnt_q;
  assign timeout_err_o = terr_q;

endmodule

// File: tb/tb_wb_stream_reader_seq.sv
// Bench for wb_stream_reader_seq: a cfg-slave/reader model that acks writes and raises irqs,
// a transaction-level scoreboard of the expected write stream, and per-cycle output checks.
module tb_wb_stream_reader_seq;
  localparam int unsigned AW = 32, DW = 32, IW = 4, TW = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic go = 1'b0, stop = 1'b0, irq = 1'b0, ack = 1'b0;
  logic [AW-1:0] base = '0, stride = '0, bsz = '0, burst = '0;
  logic [IW-1:0] num = '0;
  logic [TW-1:0] tmo = '0;
  logic [4:0] adr;
  logic [DW-1:0] dat;
  logic [DW/8-1:0] sel;
  logic we, cyc, stb, running, done, terr;
  logic [IW-1:0] idx;
  logic [31:0] fcnt;

  wb_stream_reader_seq #(.WB_AW(AW), .WB_DW(DW), .IDX_W(IW), .TMO_W(TW)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .go_i(go), .stop_i(stop),
    .ring_base_i(base), .buf_stride_i(stride), .num_bufs_i(num), .buf_size_i(bsz),
    .burst_size_i(burst), .timeout_i(tmo), .rdr_irq_i(irq),
    .wbm_adr_o(adr), .wbm_dat_o(dat), .wbm_sel_o(sel), .wbm_we_o(we), .wbm_cyc_o(cyc),
    .wbm_stb_o(stb), .wbm_ack_i(ack), .running_o(running), .cur_idx_o(idx),
    .frame_done_o(done), .frame_cnt_o(fcnt), .timeout_err_o(terr)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model state
  typedef struct packed { logic [4:0] a; logic [31:0] d; } wr_t;
  wr_t exp_q[$];
  logic [31:0] adr_hist[$];
  bit m_running, m_stop, m_terr, m_done;
  int unsigned m_cnt;
  logic [IW-1:0] m_idx, m_last;
  logic [AW-1:0] m_addr;

  int ack_dly = 1, irq_dly = 20, irq_cnt = 0, wait_cnt = 0;
  int en_count = 0, cycle_no = 0, en_cycle = 0, tmo_gap = -1;
  logic cyc_prev = 1'b0;
  logic [4:0] a0;
  logic [31:0] d0;

  logic go_s, stop_s, ack_s;
  logic [4:0] adr_s;
  logic [31:0] dat_s;
  always @(posedge clk) begin
    go_s <= go; stop_s <= stop; ack_s <= ack; adr_s <= adr; dat_s <= dat;
  end

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic log_write(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL unexpected_write: got adr=%0h dat=%0h expected none", a, d);
    end else begin
      e = exp_q.pop_front();
      chk("write_adr", a, e.a);
      chk("write_dat", d, e.d);
      if (e.a == 5'h04) adr_hist.push_back(e.d);
      if (e.a == 5'h00 && e.d == 32'h3) begin
        en_count++; en_cycle = cycle_no; irq = 1'b0; irq_cnt = irq_dly;
        push(5'h00, (irq_dly == 0 && tmo != 0) ? 32'h4 : 32'h2);
      end else if (e.a == 5'h00 && e.d == 32'h2) begin
        irq = 1'b0; m_cnt++; m_done = 1'b1;
        if (m_idx == m_last) begin m_idx = '0; m_addr = base; end
        else begin m_idx = m_idx + 1'b1; m_addr = m_addr + stride; end
        if (m_stop) begin m_running = 1'b0; m_stop = 1'b0; end
        else begin push(5'h04, m_addr); push(5'h00, 32'h3); end
      end else if (e.a == 5'h00 && e.d == 32'h4) begin
        irq = 1'b0; m_running = 1'b0; m_terr = 1'b1; m_stop = 1'b0;
      end
    end
  endtask

  // Slave, reader irq model and the per-cycle compare process.
  initial begin
    forever begin
      @(negedge clk);
      cycle_no++;
      if (!rst_n) begin
        m_running = 0; m_stop = 0; m_terr = 0; m_done = 0; m_cnt = 0;
        m_idx = '0; m_last = '0; m_addr = '0; exp_q.delete();
        ack = 1'b0; irq = 1'b0; irq_cnt = 0; wait_cnt = 0; cyc_prev = 1'b0;
      end else begin
        m_done = 1'b0;
        if (stop_s && m_running) m_stop = 1'b1;
        if (go_s && !stop_s && !m_running) begin
          m_running = 1; m_stop = 0; m_cnt = 0; m_terr = 0; m_idx = '0; m_addr = base;
          m_last = (num == 0) ? '0 : num - 1'b1;
          exp_q.delete();
          push(5'h08, bsz); push(5'h0C, burst); push(5'h04, base); push(5'h00, 32'h3);
        end
        if (ack_s) log_write(adr_s, dat_s);
        if (cyc_prev) chk("cyc_hold_until_ack", cyc, !ack_s);
        chk("bus_ctl", {we, stb, sel}, cyc ? 6'h3F : 6'h00);
        chk("running", running, m_running);
        chk("frame_cnt", fcnt, m_cnt);
        chk("cur_idx", idx, m_idx);
        chk("frame_done", done, m_done);
        chk("timeout_err", terr, m_terr);
        if (cyc) begin
          if (wait_cnt == 0) begin
            a0 = adr; d0 = dat;
            if (exp_q.size() > 0 && exp_q[0].a == 5'h00 && exp_q[0].d == 32'h4)
              tmo_gap = cycle_no - en_cycle;
          end else begin
            chk("adr_dat_stable", {adr, dat}, {a0, d0});
          end
          wait_cnt++;
          ack = (wait_cnt >= ack_dly);
        end else begin
          wait_cnt = 0;
          ack = 1'b0;
        end
        if (irq_cnt > 0) begin
          irq_cnt--;
          if (irq_cnt == 0) irq = 1'b1;
        end
        cyc_prev = cyc;
      end
    end
  end

  task automatic pulse_go();
    go = 1'b1; @(negedge clk); go = 1'b0; @(negedge clk);
  endtask

  task automatic pulse_stop();
    stop = 1'b1; @(negedge clk); stop = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string name);
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (!running && !m_running) return;
    end
    checks++; failures++;
    $display("FAIL %s: got running after %0d cycles expected idle", name, maxc);
  endtask

  task automatic wait_en(input int n, input int maxc, input string name);
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (en_count >= n) return;
    end
    checks++; failures++;
    $display("FAIL %s: got %0d enables expected %0d", name, en_count, n);
  endtask

  task automatic setup(input logic [31:0] b, input logic [31:0] s, input logic [3:0] n);
    base = b; stride = s; num = n; bsz = 32'h400; burst = 32'd16;
    en_count = 0; adr_hist.delete();
  endtask

  initial begin
    logic [31:0] exp_h [4];
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_running", running, 0);
    chk("rst_cyc", cyc, 0);
    chk("rst_frame_cnt", fcnt, 0);
    chk("rst_idx", idx, 0);
    chk("rst_terr", terr, 0);

    // Three-buffer ring, four frames, then stop
    setup(32'h1000, 32'h400, 4'd3); ack_dly = 1; irq_dly = 20; tmo = '0;
    pulse_go();
    wait_en(4, 600, "t1_enables");
    pulse_stop();
    wait_idle(200, "t1_idle");
    chk("t1_frame_cnt", fcnt, 32'd4);
    chk("t1_idx", idx, 4'd1);
    chk("t1_hist_size", adr_hist.size(), 4);
    exp_h = '{32'h1000, 32'h1400, 32'h1800, 32'h1000};
    for (int i = 0; i < 4; i++)
      chk("t1_hist", (i < adr_hist.size()) ? adr_hist[i] : 32'hDEAD, exp_h[i]);

    // Stop mid-WAIT of frame 1 lets that frame finish, then nothing more
    setup(32'h1000, 32'h400, 4'd3);
    pulse_go();
    wait_en(1, 100, "t2_enable");
    repeat (3) @(negedge clk);
    pulse_stop();
    wait_idle(100, "t2_idle");
    repeat (30) @(negedge clk);
    chk("t2_frame_cnt", fcnt, 32'd1);
    chk("t2_pending_writes", exp_q.size(), 0);

    // Watchdog expiry
    setup(32'h1000, 32'h400, 4'd3); tmo = 24'd50; irq_dly = 0;
    pulse_go();
    wait_idle(400, "t3_idle");
    chk("t3_tmo_gap", tmo_gap, 51);
    chk("t3_terr", terr, 1);
    chk("t3_running", running, 0);
    go = 1'b1; stop = 1'b1; @(negedge clk); go = 1'b0; stop = 1'b0;
    repeat (5) @(negedge clk);
    chk("t3_go_with_stop_idle", running, 0);
    chk("t3_terr_kept", terr, 1);
    tmo = '0; irq_dly = 3;
    go = 1'b1; @(negedge clk); go = 1'b0; stop = 1'b1; @(negedge clk); stop = 1'b0;
    @(negedge clk);
    chk("t3_terr_cleared", terr, 0);
    wait_idle(200, "t3b_idle");
    chk("t3b_frame_cnt", fcnt, 32'd1);

    // Slow slave: five-cycle ack latency
    setup(32'h1000, 32'h400, 4'd3); ack_dly = 5; irq_dly = 4;
    pulse_go();
    wait_en(2, 400, "t4_enables");
    pulse_stop();
    wait_idle(200, "t4_idle");
    chk("t4_frame_cnt", fcnt, 32'd2);
    chk("t4_hist1", (adr_hist.size() > 1) ? adr_hist[1] : 32'hDEAD, 32'h1400);

    // num_bufs = 0 behaves as a single buffer
    setup(32'h2000, 32'h100, 4'd0); ack_dly = 1; irq_dly = 6;
    pulse_go();
    wait_en(3, 300, "t5_enables");
    pulse_stop();
    wait_idle(200, "t5_idle");
    chk("t5_idx", idx, 4'd0);
    chk("t5_frame_cnt", fcnt, 32'd3);
    for (int i = 0; i < 3; i++)
      chk("t5_hist", (i < adr_hist.size()) ? adr_hist[i] : 32'hDEAD, 32'h2000);

    // Reset asserted while the reg1 write is on the bus
    setup(32'h1000, 32'h400, 4'd3); ack_dly = 3; irq_dly = 5;
    pulse_go();
    for (int i = 0; i < 100; i++) begin
      if (cyc && adr == 5'h04) break;
      @(negedge clk);
    end
    chk("t6_reached_wr_adr", {cyc, adr}, {1'b1, 5'h04});
    #2 rst_n = 1'b0;
    #1;
    chk("t6_cyc_drop", cyc, 0);
    chk("t6_stb_drop", stb, 0);
    chk("t6_running_drop", running, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6_stays_idle", running, 0);
    chk("t6_frame_cnt", fcnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
